// File: rtl/demux_1to4_reg_pkg.sv
// Shared constants and slot state encoding for the 1-to-4 registered demux.
package demux_1to4_reg_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;
endpackage

// File: rtl/demux_ch_slot.sv
// One-entry holding register for a single output channel.
// A load always wins over a drain, so a simultaneous drain+load stays FULL
// with the new word and no bubble is inserted.
module demux_ch_slot
  import demux_1to4_reg_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  slot_state_t state, state_nxt;

  // State register; reset discards any held word.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Next state: load fills, drain without load empties.
  always_comb begin
    state_nxt = state;
    if (load)                        state_nxt = FULL;
    else if (state == FULL && ready) state_nxt = EMPTY;
  end

  // Data only changes on load, so it holds while stalled and after drain.
  always_ff @(posedge clk) begin
    if (!rst_n)    data <= '0;
    else if (load) data <= load_data;
  end

  assign valid = (state == FULL);

endmodule

// File: rtl/demux_1to4_reg.sv
// 1-to-4 demux with a one-entry register per channel and per-channel
// valid/ready handshakes. Top holds select decode, in_ready mux and counter.
module demux_1to4_reg
  import demux_1to4_reg_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [CNT_W-1:0]        xfer_cnt
);

  logic              accept;
  logic [NUM_CH-1:0] load;

  // Only the selected slot gates acceptance; in_valid is not involved.
  assign in_ready = rst_n & (~out_valid[in_sel] | out_ready[in_sel]);
  assign accept   = in_valid & in_ready;

  // One-hot load strobe for the selected channel.
  always_comb begin
    load         = '0;
    load[in_sel] = accept;
  end

  // Accepted-word counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n)      xfer_cnt <= '0;
    else if (accept) xfer_cnt <= xfer_cnt + 1'b1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    demux_ch_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[g]),
      .load_data (in_data),
      .ready     (out_ready[g]),
      .data      (out_data[g*WIDTH +: WIDTH]),
      .valid     (out_valid[g])
    );
  end

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Scoreboard bench: accepted words are queued per channel, a monitor pops
// and compares every drained word; directed checks cover handshake state.
module tb_demux_1to4_reg;
  localparam int W  = 4;
  localparam int CW = 8;
  typedef logic [W-1:0] word_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic [1:0]    in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [4*W-1:0] out_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [CW-1:0] xfer_cnt;

  int    n_vec = 0;
  int    n_bad = 0;
  word_t exp_q [4][$];
  word_t mon_e;

  demux_1to4_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ch(input int c, input word_t exp);
    check($sformatf("ch%0d data", c), 32'(out_data[c*W +: W]), 32'(exp));
  endtask

  // Offer one word for one cycle; push it if it is expected to be accepted.
  task automatic offer(input logic [1:0] sel, input word_t d, input logic acc);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    @(negedge clk);
    check($sformatf("in_ready sel%0d", sel), 32'(in_ready), 32'(acc));
    if (acc) exp_q[sel].push_back(d);
    @(posedge clk); #1;
  endtask

  // Monitor: every drain (valid & ready, out of reset) must match the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int c = 0; c < 4; c++) begin
        if (out_valid[c] && out_ready[c]) begin
          if (exp_q[c].size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain ch%0d: got %0h expected no word", c, out_data[c*W +: W]);
          end else begin
            mon_e = exp_q[c].pop_front();
            check($sformatf("drain ch%0d", c), 32'(out_data[c*W +: W]), 32'(mon_e));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst xfer_cnt", 32'(xfer_cnt), 32'h0);
    check("rst out_data", 32'(out_data), 32'h0);
    check("rst in_ready", 32'(in_ready), 32'h0);

    // Out of reset every channel is ready.
    rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s); #1;
      check($sformatf("post-rst in_ready sel%0d", s), 32'(in_ready), 32'h1);
    end
    @(posedge clk); #1;

    // Single word to ch2.
    offer(2'd2, 4'h1, 1'b1);
    in_valid = 1'b0;
    check("ch2 out_valid", 32'(out_valid), 32'h4);
    chk_ch(2, 4'h1);
    check("xfer 1", 32'(xfer_cnt), 32'd1);
    out_ready = 4'b0100;
    @(posedge clk); #1;
    out_ready = 4'b0000;
    check("ch2 drained", 32'(out_valid), 32'h0);

    // Fill all four channels, no consumers.
    offer(2'd0, 4'h3, 1'b1);
    offer(2'd1, 4'h5, 1'b1);
    offer(2'd2, 4'h9, 1'b1);
    offer(2'd3, 4'hC, 1'b1);
    in_valid = 1'b0;
    check("all full", 32'(out_valid), 32'hF);
    check("xfer 5", 32'(xfer_cnt), 32'd5);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s); #1;
      check($sformatf("full in_ready sel%0d", s), 32'(in_ready), 32'h0);
    end
    out_ready = 4'b1000;
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s); #1;
      check($sformatf("ch3 drain in_ready sel%0d", s), 32'(in_ready), (s == 3) ? 32'h1 : 32'h0);
    end
    @(posedge clk); #1;
    out_ready = 4'b0000;
    check("ch3 drained", 32'(out_valid), 32'h7);

    // Stall on full ch1, then drain+load in the same cycle.
    offer(2'd1, 4'hE, 1'b0);
    in_valid = 1'b0;
    check("stall out_valid", 32'(out_valid), 32'h7);
    check("stall xfer", 32'(xfer_cnt), 32'd5);
    chk_ch(1, 4'h5);
    out_ready = 4'b0010;
    offer(2'd1, 4'hA, 1'b1);
    in_valid = 1'b0;
    out_ready = 4'b0000;
    check("no bubble", 32'(out_valid), 32'h7);
    chk_ch(1, 4'hA);
    chk_ch(0, 4'h3);
    check("xfer 6", 32'(xfer_cnt), 32'd6);

    // Drain ch2 while loading ch3 -> 1011, then reset mid-operation.
    out_ready = 4'b0100;
    offer(2'd3, 4'h7, 1'b1);
    in_valid = 1'b0;
    out_ready = 4'b0000;
    check("pre-rst out_valid", 32'(out_valid), 32'hB);
    check("xfer 7", 32'(xfer_cnt), 32'd7);
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 2'd2; in_data = 4'hF;
    #1;
    check("in rst in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    check("mid-rst out_valid", 32'(out_valid), 32'h0);
    check("mid-rst xfer", 32'(xfer_cnt), 32'h0);
    check("mid-rst out_data", 32'(out_data), 32'h0);
    for (int c = 0; c < 4; c++) exp_q[c].delete();
    in_valid = 1'b0;
    rst_n = 1'b1;

    // 256 back-to-back accepts with all consumers ready: counter wraps.
    out_ready = 4'b1111;
    for (int i = 0; i < 256; i++) begin
      offer(2'(i % 4), W'(i), 1'b1);
      if (i == 254) check("xfer 255", 32'(xfer_cnt), 32'd255);
    end
    in_valid = 1'b0;
    check("xfer wrap", 32'(xfer_cnt), 32'd0);
    @(posedge clk); #1;
    out_ready = 4'b0000;
    check("final out_valid", 32'(out_valid), 32'h0);
    for (int c = 0; c < 4; c++)
      check($sformatf("queue ch%0d empty", c), 32'(exp_q[c].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
